// File: rtl/m68k_bus_target.sv
// 68000 asynchronous-bus responder: decodes one window and bridges each cycle to a req/ack backend.
// Optional macro M68K_BUS_TARGET_TIMEOUT_EN adds a backend timeout that answers with berr_n.
module m68k_bus_target #(
  parameter logic [22:0] BASE        = 23'h300000,
  parameter logic [22:0] MASK        = 23'h780000,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        as_n,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic        rw,
  input  logic [22:0] addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        dtack_n,
  output logic        berr_n,
  output logic        req,
  output logic        we,
  output logic [1:0]  be,
  output logic [22:0] baddr,
  output logic [15:0] wdata,
  input  logic [15:0] rdata,
  input  logic        ack
);

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned TMO_W  = 16;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES - 1);

  if (WAIT_STATES > 15) begin : g_bad_wait
    $error("WAIT_STATES must be 0..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("TIMEOUT must be 1..65535");
  end

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_ACK  = 3'd3
`ifdef M68K_BUS_TARGET_TIMEOUT_EN
    , ST_ERR = 3'd4
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
  logic                armed_q, armed_d;
  logic                abort_q, abort_d;

  logic [15:0]         dout_d;
  logic                dtack_n_d;
  logic                req_d;
  logic                we_d;
  logic [1:0]          be_d;
  logic [22:0]         baddr_d;
  logic [15:0]         wdata_d;

  logic                sel_c;
  logic                start_c;

  // armed_q is set by any clock with as_n high, so a cycle is only accepted on a fresh strobe
  assign sel_c   = ((addr & MASK) == BASE);
  assign start_c = armed_q & ~as_n & ~(uds_n & lds_n) & sel_c;

`ifdef M68K_BUS_TARGET_TIMEOUT_EN
  logic [TMO_W-1:0]    tcnt_q, tcnt_d;
  logic                berr_n_d;
  logic                tmo_hit_c;

  assign tmo_hit_c = ((tcnt_q + TMO_W'(1)) == TMO_W'(TIMEOUT));
`else
  assign berr_n = 1'b1;
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      armed_q <= 1'b1;
      abort_q <= 1'b0;
      dout    <= '0;
      dtack_n <= 1'b1;
      req     <= 1'b0;
      we      <= 1'b0;
      be      <= '0;
      baddr   <= '0;
      wdata   <= '0;
`ifdef M68K_BUS_TARGET_TIMEOUT_EN
      tcnt_q  <= '0;
      berr_n  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      armed_q <= armed_d;
      abort_q <= abort_d;
      dout    <= dout_d;
      dtack_n <= dtack_n_d;
      req     <= req_d;
      we      <= we_d;
      be      <= be_d;
      baddr   <= baddr_d;
      wdata   <= wdata_d;
`ifdef M68K_BUS_TARGET_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      berr_n  <= berr_n_d;
`endif
    end
  end

  // Next-state and counters
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    abort_d = abort_q;
    armed_d = armed_q;
`ifdef M68K_BUS_TARGET_TIMEOUT_EN
    tcnt_d  = tcnt_q;
`endif
    if (as_n)
      armed_d = 1'b1;
    else if ((state_q == ST_IDLE) && start_c)
      armed_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          state_d = ST_REQ;
          abort_d = 1'b0;
`ifdef M68K_BUS_TARGET_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end
      end
      ST_REQ: begin
        // the backend request cannot be withdrawn, so an abort only suppresses dtack_n
        if (as_n)
          abort_d = 1'b1;
        if (ack) begin
          if (abort_q || as_n)
            state_d = ST_IDLE;
          else if (WAIT_STATES == 0)
            state_d = ST_ACK;
          else begin
            state_d = ST_WAIT;
            wcnt_d  = WAIT_LOAD;
          end
        end
`ifdef M68K_BUS_TARGET_TIMEOUT_EN
        else if (tmo_hit_c)
          state_d = (abort_q || as_n) ? ST_IDLE : ST_ERR;
        else
          tcnt_d = tcnt_q + TMO_W'(1);
`endif
      end
      ST_WAIT: begin
        if (as_n)
          state_d = ST_IDLE;
        else if (wcnt_q == '0)
          state_d = ST_ACK;
        else
          wcnt_d = wcnt_q - WAIT_W'(1);
      end
      ST_ACK: begin
        if (as_n)
          state_d = ST_IDLE;
      end
`ifdef M68K_BUS_TARGET_TIMEOUT_EN
      ST_ERR: begin
        if (as_n)
          state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; strobes follow the next state
  always_comb begin
    dout_d    = dout;
    req_d     = req;
    we_d      = we;
    be_d      = be;
    baddr_d   = baddr;
    wdata_d   = wdata;
    dtack_n_d = (state_d != ST_ACK);
`ifdef M68K_BUS_TARGET_TIMEOUT_EN
    berr_n_d  = (state_d != ST_ERR);
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          req_d   = 1'b1;
          we_d    = ~rw;
          be_d    = ~{uds_n, lds_n};
          baddr_d = addr;
          wdata_d = din;
        end
      end
      ST_REQ: begin
        if (ack) begin
          req_d = 1'b0;
          if (!we)
            dout_d = rdata;
        end
`ifdef M68K_BUS_TARGET_TIMEOUT_EN
        else if (tmo_hit_c)
          req_d = 1'b0;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_m68k_bus_target.sv
// Self-checking bench for m68k_bus_target: vector table, random cycles and hand-written corner sequences.
module tb_m68k_bus_target;

  localparam logic [22:0] BASE = 23'h300000;
  localparam logic [22:0] MASK = 23'h780000;
  localparam int          WS   = 1;
  localparam int unsigned TMO  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        as_n, uds_n, lds_n, rw;
  logic [22:0] addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        dtack_n, berr_n, req, we;
  logic [1:0]  be;
  logic [22:0] baddr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_dout = 16'h0000;

  always #5 clk = ~clk;

  m68k_bus_target #(
    .BASE(BASE), .MASK(MASK), .WAIT_STATES(WS), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n),
    .rw(rw), .addr(addr), .din(din), .dout(dout), .dtack_n(dtack_n),
    .berr_n(berr_n), .req(req), .we(we), .be(be), .baddr(baddr),
    .wdata(wdata), .rdata(rdata), .ack(ack)
  );

  typedef struct {
    logic [22:0] a;
    logic        u;
    logic        l;
    logic        r;
    logic [15:0] d;
    logic [15:0] rd;
    int          dly;
    bit          exp_sel;
    logic [1:0]  exp_be;
    logic        exp_we;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference decode straight from the window/strobe rules
  function automatic vec_t rand_vec();
    vec_t v;
    logic [1:0] st;
    v.a = ($urandom_range(0, 1) == 1) ? (BASE | (23'($urandom) & ~MASK)) : 23'($urandom);
    st = 2'($urandom_range(0, 2));
    if ($urandom_range(0, 7) == 0) st = 2'b11;
    {v.u, v.l} = st;
    v.r  = 1'($urandom_range(0, 1));
    v.d  = 16'($urandom);
    v.rd = 16'($urandom);
    v.dly = int'($urandom_range(0, 4));
    v.exp_sel = ((v.a & MASK) == BASE) && (st != 2'b11);
    v.exp_be  = ~st;
    v.exp_we  = ~v.r;
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    int n;
    @(negedge clk);
    addr = v.a; uds_n = v.u; lds_n = v.l; rw = v.r; din = v.d; as_n = 1'b0;
    @(negedge clk);
    chk("req_start", req, v.exp_sel);
    chk("dtack_idle", dtack_n, 1);
    if (!v.exp_sel) begin
      repeat (3) @(negedge clk);
      chk("req_unsel", req, 0);
      chk("dtack_unsel", dtack_n, 1);
      as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
      return;
    end
    chk("baddr", baddr, v.a);
    chk("we", we, v.exp_we);
    chk("be", be, v.exp_be);
    chk("wdata", wdata, v.d);
    for (int i = 0; i < v.dly; i++) @(negedge clk);
    chk("req_held", req, 1);
    ack = 1'b1; rdata = v.rd;
    @(negedge clk);
    ack = 1'b0; rdata = 16'($urandom);
    chk("req_drop", req, 0);
    n = 0;
    while (dtack_n === 1'b1 && n < WS + 4) begin
      @(negedge clk);
      n++;
    end
    chk("dtack_lat", n, WS);
    if (v.r) exp_dout = v.rd;
    chk("dout", dout, exp_dout);
    repeat (2) @(negedge clk);
    chk("dtack_hold", dtack_n, 0);
    chk("dout_hold", dout, exp_dout);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    @(negedge clk);
    chk("dtack_release", dtack_n, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    addr = '0; din = '0; rdata = '0; ack = 1'b0;

    tbl[0] = '{23'h300008, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hBEEF, 3, 1'b1, 2'b11, 1'b0};
    tbl[1] = '{23'h300010, 1'b1, 1'b0, 1'b0, 16'h00A5, 16'h0000, 1, 1'b1, 2'b01, 1'b1};
    tbl[2] = '{23'h000100, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h1111, 0, 1'b0, 2'b11, 1'b0};
    tbl[3] = '{23'h37FFFF, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h1234, 0, 1'b1, 2'b10, 1'b0};
    tbl[4] = '{23'h380000, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h2222, 0, 1'b0, 2'b11, 1'b0};
    tbl[5] = '{23'h300020, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h3333, 0, 1'b0, 2'b00, 1'b0};
    tbl[6] = '{23'h305555, 1'b0, 1'b0, 1'b0, 16'hCAFE, 16'h4444, 2, 1'b1, 2'b11, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_dtack", dtack_n, 1);
    chk("rst_berr", berr_n, 1);
    chk("rst_req", req, 0);
    chk("rst_we", we, 0);
    chk("rst_be", be, 0);
    chk("rst_baddr", baddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_dout", dout, 0);
    rst_n = 1'b1;

    // stray ack outside REQ
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    chk("stray_ack_req", req, 0);
    chk("stray_ack_dtack", dtack_n, 1);

    foreach (tbl[i]) run_txn(tbl[i]);
    for (int i = 0; i < 30; i++) run_txn(rand_vec());

    // aborted cycle: as_n rises after req, ack arrives later, no dtack_n
    @(negedge clk);
    addr = 23'h300040; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; as_n = 1'b0;
    @(negedge clk);
    chk("abort_req", req, 1);
    @(negedge clk);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    chk("abort_dtack0", dtack_n, 1);
    @(negedge clk);
    chk("abort_dtack1", dtack_n, 1);
    @(negedge clk);
    chk("abort_req_held", req, 1);
    ack = 1'b1; rdata = 16'h5A5A;
    @(negedge clk);
    ack = 1'b0;
    chk("abort_req_drop", req, 0);
    chk("abort_dtack2", dtack_n, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_dtack", dtack_n, 1);
    end
    run_txn(tbl[0]);

    // backend never answers
    @(negedge clk);
    addr = 23'h300080; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; as_n = 1'b0;
    @(negedge clk);
    chk("tmo_req", req, 1);
`ifdef M68K_BUS_TARGET_TIMEOUT_EN
    n = 0;
    while (req === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_len", n, TMO);
    chk("tmo_berr", berr_n, 0);
    chk("tmo_dtack", dtack_n, 1);
    @(negedge clk); ack = 1'b1; rdata = 16'h9999;
    @(negedge clk); ack = 1'b0;
    chk("tmo_late_ack_berr", berr_n, 0);
    chk("tmo_late_ack_req", req, 0);
    chk("tmo_late_ack_dout", dout, exp_dout);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    @(negedge clk);
    chk("tmo_berr_release", berr_n, 1);
`else
    repeat (12) @(negedge clk);
    chk("notmo_berr", berr_n, 1);
    chk("notmo_req", req, 1);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    ack = 1'b1; rdata = exp_dout;
    @(negedge clk);
    ack = 1'b0;
    chk("notmo_req_drop", req, 0);
    @(negedge clk);
    chk("notmo_dtack", dtack_n, 1);
`endif

    // asynchronous reset while in WAIT
    @(negedge clk);
    addr = 23'h300100; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; as_n = 1'b0;
    @(negedge clk);
    chk("wrst_req", req, 1);
    ack = 1'b1; rdata = 16'h1357;
    @(posedge clk);
    #2;
    ack = 1'b0;
    chk("wrst_pre_dout", dout, 16'h1357);
    rst_n = 1'b0;
    #1;
    chk("wrst_dtack", dtack_n, 1);
    chk("wrst_req0", req, 0);
    chk("wrst_dout", dout, 0);
    chk("wrst_berr", berr_n, 1);
    exp_dout = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    run_txn(tbl[1]);
    run_txn(tbl[3]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/m68k_bus_target.md
# m68k_bus_target

Responder side of the 68000 asynchronous bus, acting as the slave counterpart to the fx68k initiator. It decodes one address window, captures address, byte-lane strobes and write data, and runs a single-outstanding req/ack transaction on a simple synchronous backend port. When the backend responds it drives read data and asserts `dtack_n` after a programmable number of wait states. It is placed between the CPU bus and any peripheral or memory that cannot respond in a fixed zero-wait cycle.

## Interface
- `BASE`, 23'h300000 — window base on word-address bits [23:1].
- `MASK`, 23'h780000 — bits compared; the window is selected when `(addr & MASK) == BASE`.
- `WAIT_STATES`, 1 — extra clocks inserted between backend `ack` and `dtack_n` assertion; range 0–15.
- `TIMEOUT`, 255 — backend clocks allowed before a bus error; range 1–65535; used only with the timeout macro.

- `clk` in 1 — system clock; all CPU bus inputs are synchronous to it.
- `rst_n` in 1 — asynchronous, active-low reset.
- `as_n` in 1 — address strobe.
- `uds_n` in 1 — upper data strobe.
- `lds_n` in 1 — lower data strobe.
- `rw` in 1 — 1 = read, 0 = write.
- `addr` in 23 — CPU word address [23:1].
- `din` in 16 — CPU write data.
- `dout` out 16 — read data to the CPU.
- `dtack_n` out 1 — data transfer acknowledge.
- `berr_n` out 1 — bus error.
- `req` out 1 — backend request; a level held until `ack`.
- `we` out 1 — backend write.
- `be` out 2 — byte enables {upper, lower}, active high.
- `baddr` out 23 — latched word address.
- `wdata` out 16 — latched write data.
- `rdata` in 16 — backend read data; valid when `ack` = 1.
- `ack` in 1 — backend completion; a one-clock pulse.

## Operation
- Reset values: `dtack_n`=1, `berr_n`=1, `req`=0, `we`=0, `be`=0, `baddr`=0, `wdata`=0, `dout`=0. FSM is in IDLE; counters are 0.
- **IDLE**: the FSM leaves IDLE when `as_n`=0, `{uds_n,lds_n}`≠2'b11, and the address is in the window.
  - It latches `baddr`=`addr`, `we`=~`rw`, `be`=~{`uds_n`,`lds_n`}, and `wdata`=`din`.
  - It sets `req`=1 and goes to REQ.
  - An address outside the window is ignored: all outputs stay idle.
- **REQ**: `req` is held.
  - On `ack`=1: `req`→0. On a read, `dout`←`rdata`.
  - If `WAIT_STATES`=0 the FSM goes to ACK; otherwise it loads the wait counter and goes to WAIT.
- **WAIT**: the counter decrements each clock. When it reaches 0 the FSM goes to ACK.
- **ACK**: `dtack_n`=0 and `dout` is held stable until `as_n` is sampled 1. Then `dtack_n`→1 and the FSM goes to IDLE.
- **Aborted cycle**: `as_n` goes high before ACK.
  - A backend request already issued runs to `ack`; it cannot be cancelled.
  - `dtack_n` is never asserted for that cycle, and the FSM goes to IDLE after `ack`.
- **Re-entry**: a new cycle is not accepted in the same clock that `as_n` is sampled 1. IDLE requires a fresh `as_n` low, which forces at least one idle clock between transactions.
- **Reset**: asserting `rst_n` mid-transaction immediately returns all outputs to their reset values. The backend must tolerate `req` dropping without `ack`.
- `ack` arriving while not in REQ is ignored.

## Timing
- Inputs are sampled at rising edge N in IDLE → `req`=1 after edge N.
- `ack` is sampled at edge M → `dtack_n`=0 after edge M+`WAIT_STATES`.
- `dout` becomes valid no later than `dtack_n` falls.
- `as_n`=1 is sampled at edge K → `dtack_n`=1 and `berr_n`=1 after edge K.
- Minimum read latency, from the `req` edge to `dtack_n` low, is 1+`WAIT_STATES` clocks with a same-cycle `ack`.

## Configuration
- **`M68K_BUS_TARGET_TIMEOUT_EN` defined**:
  - A 16-bit counter clears on REQ entry and increments every clock while in REQ.
  - When it reaches `TIMEOUT` without `ack`: `req`→0, the FSM enters ERR, and `berr_n`=0 (`dtack_n` stays 1) until `as_n` is sampled 1.
  - A late `ack` is ignored.
- **Not defined**: REQ waits indefinitely, `berr_n` is constant 1, and no ERR state or counter is built.

## Test plan
- Read 0x600010 (`addr`=23'h300008, both strobes low), `rdata`=16'hBEEF, `ack` 3 clocks after `req`, `WAIT_STATES`=1 → `be`=2'b11, `we`=0, `dtack_n` low 1 clock after `ack`, `dout`=16'hBEEF until `as_n` rises.
- Byte write to the lower lane (`uds_n`=1, `lds_n`=0), `din`=16'h00A5 → `be`=2'b01, `we`=1, `wdata`=16'h00A5; `dtack_n` drops, then releases one edge after `as_n` rises.
- `addr`=23'h000100, `as_n` low → `req` never asserts and `dtack_n` stays 1.
- `as_n` rises 1 clock after `req` and `ack` follows 2 clocks later → no `dtack_n` pulse, FSM back in IDLE, next in-window cycle served normally.
- With the macro, `TIMEOUT`=8 and no `ack` → `req` drops and `berr_n`=0 at the 8th REQ clock, released after `as_n` rises; without the macro `berr_n` stays 1.
- `rst_n` pulsed low during WAIT → `dtack_n`=1, `req`=0 and `dout`=0 immediately, without waiting for a clock edge.
